exc_sequencer: RTL and testbench
================================

Name: exc_sequencer

Overview:
- Sequences exception, interrupt and ERET entry between the MEM stage, the bus interfaces and the CP0 register file.
- Captures the victim instruction and holds the pipeline, then waits for outstanding bus traffic to drain.
- Issues a single-cycle commit strobe to CP0, then drives the PC redirect handshake to the fetch unit until it is accepted.

Parameters:
- DRAIN_MAX, 64: maximum drain-wait cycles before a forced commit (≥2).
- CNT_W, 16: width of the saturating exception-count statistic.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM stage holds a real instruction
- mem_exc_type  in  8  exception vector, CP0 encoding: [6] AdEL, [7] AdES, [1] Sys, [0] Bp, [2] RI, [3] Ov, [4] Tr, [5] ERET
- mem_pc  in  32  MEM instruction PC
- mem_is_delayslot  in  1  MEM instruction is in a delay slot
- mem_badvaddr  in  32  faulting data address
- int_pending  in  1  CP0 reports an enabled, unmasked interrupt
- bus_busy  in  1  instruction or data bus has an outstanding transaction
- cp0_exc_en  in  1  CP0 combinational exc_en
- cp0_pc_exc  in  32  CP0 combinational target PC
- redirect_ready  in  1  fetch accepts the redirect
- stall  out  1  freeze IF..MEM
- flush  out  1  invalidate IF..MEM
- cp0_exc_type  out  8  exception vector presented to CP0
- cp0_victim_pc  out  32  captured PC
- cp0_is_delayslot  out  1  captured delay-slot flag
- cp0_badvaddr  out  32  captured bad address
- cp0_int_commit  out  1  interrupt-entry strobe to CP0
- redirect_valid  out  1  redirect request
- redirect_pc  out  32  redirect target
- drain_timeout  out  1  sticky flag: a drain hit DRAIN_MAX
- exc_count  out  CNT_W  number of commits, saturating

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - All outputs are 0, including the captured registers, exc_count and drain_timeout.
  - A reset mid-sequence abandons the sequence; no CP0 strobe is issued afterwards.
- States: IDLE, DRAIN, COMMIT, REDIRECT. The encoding is free.
- IDLE:
  - Trigger condition: mem_valid && (mem_exc_type != 0 || int_pending).
  - On trigger, register mem_exc_type into the capture register (0 for an interrupt-only trigger), along with mem_pc, mem_is_delayslot, mem_badvaddr, and an int flag = (mem_exc_type == 0).
  - Exceptions take priority over interrupts: if both are present, capture the exception type and clear the int flag.
  - Next state: DRAIN if bus_busy, else COMMIT.
  - stall goes high on the cycle after the trigger. A trigger on the same cycle is not stalled combinationally.
- DRAIN:
  - stall=1. The drain counter increments each cycle.
  - Go to COMMIT on the first cycle bus_busy=0, or when the counter reaches DRAIN_MAX-1.
  - A timeout sets drain_timeout (sticky until reset). The counter clears on DRAIN exit.
  - ERET with bus_busy=0 goes straight to COMMIT. Any ERET is otherwise treated like an exception.
- COMMIT (exactly 1 cycle):
  - cp0_exc_type = captured type.
  - cp0_int_commit = int flag.
  - stall=1, flush=1.
  - Latch redirect_pc = cp0_pc_exc if cp0_exc_en, else 32'hBFC00380 (fallback for an interrupt withdrawn by CP0).
  - exc_count increments, saturating at all-ones.
  - Go to REDIRECT.
  - cp0_exc_type and cp0_int_commit are 0 in every other state.
- REDIRECT:
  - redirect_valid=1, flush=1, stall=0.
  - redirect_pc is held stable while valid and not ready.
  - On redirect_ready, go to IDLE with redirect_valid=0 the next cycle.
  - Triggers are ignored in REDIRECT.
  - The first new trigger is evaluated in IDLE the cycle after exit. Flushed MEM contents are not re-sampled because flush clears mem_valid upstream.
- cp0_victim_pc, cp0_is_delayslot and cp0_badvaddr hold their captured values until the next capture.
- No combinational path from mem_* to any output.

Test Plan:
1. Sys exception, bus idle: mem_valid=1, mem_exc_type=8'h02, mem_pc=0xBFC0_0100, cp0_pc_exc=0xBFC0_0380, cp0_exc_en=1.
   - Required: COMMIT 1 cycle after the trigger, with cp0_exc_type=8'h02 for exactly 1 cycle.
   - Required: redirect_valid with redirect_pc=0xBFC0_0380; exc_count=1.
2. AdES with bus_busy held for 5 cycles, mem_badvaddr=0x8000_0003.
   - Required: stall for 5 DRAIN cycles, then COMMIT with cp0_badvaddr=0x8000_0003; drain_timeout=0.
3. Drain timeout: bus_busy stuck at 1, DRAIN_MAX=64.
   - Required: COMMIT on DRAIN cycle 64; drain_timeout=1 and remains 1 afterwards.
4. Simultaneous Ov (8'h08) and int_pending=1, with mem_is_delayslot=1.
   - Required: cp0_exc_type=8'h08, cp0_int_commit=0, cp0_is_delayslot=1.
5. Interrupt only, with redirect_ready held low for 3 cycles.
   - Required: cp0_int_commit pulses once; redirect_pc stays stable through the 3 cycles; IDLE after ready.
6. Reset asserted during DRAIN.
   - Required: all outputs 0 immediately, with no cp0_exc_type pulse after release; exc_count=0.

Source files
------------

// File: rtl/exc_sequencer.sv
// Exception/interrupt/ERET entry sequencer: capture the victim, hold the pipe, drain the bus,
// strobe CP0 for one cycle, then redirect fetch until accepted.
module exc_sequencer #(
    parameter int unsigned DRAIN_MAX = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    input  logic [7:0]       mem_exc_type,
    input  logic [31:0]      mem_pc,
    input  logic             mem_is_delayslot,
    input  logic [31:0]      mem_badvaddr,
    input  logic             int_pending,
    input  logic             bus_busy,
    input  logic             cp0_exc_en,
    input  logic [31:0]      cp0_pc_exc,
    input  logic             redirect_ready,
    output logic             stall,
    output logic             flush,
    output logic [7:0]       cp0_exc_type,
    output logic [31:0]      cp0_victim_pc,
    output logic             cp0_is_delayslot,
    output logic [31:0]      cp0_badvaddr,
    output logic             cp0_int_commit,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             drain_timeout,
    output logic [CNT_W-1:0] exc_count
);

    localparam int unsigned        DCNT_W     = $clog2(DRAIN_MAX);
    localparam logic [DCNT_W-1:0]  DRAIN_LAST = DCNT_W'(DRAIN_MAX - 1);
    localparam logic [31:0]        FALLBACK_PC = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [DCNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic               timeout_q, timeout_d;
    logic [7:0]         cap_type_q, cap_type_d;
    logic               cap_int_q, cap_int_d;
    logic [31:0]        cap_pc_q, cap_pc_d;
    logic               cap_ds_q, cap_ds_d;
    logic [31:0]        cap_bad_q, cap_bad_d;
    logic               stall_q, stall_d;
    logic               flush_q, flush_d;
    logic [7:0]         exc_type_q, exc_type_d;
    logic               int_commit_q, int_commit_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rpc_q, rpc_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               trigger_c;
    assign trigger_c = mem_valid && ((mem_exc_type != 8'h00) || int_pending);

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            drain_cnt_q  <= '0;
            timeout_q    <= 1'b0;
            cap_type_q   <= '0;
            cap_int_q    <= 1'b0;
            cap_pc_q     <= '0;
            cap_ds_q     <= 1'b0;
            cap_bad_q    <= '0;
            stall_q      <= 1'b0;
            flush_q      <= 1'b0;
            exc_type_q   <= '0;
            int_commit_q <= 1'b0;
            rvalid_q     <= 1'b0;
            rpc_q        <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            timeout_q    <= timeout_d;
            cap_type_q   <= cap_type_d;
            cap_int_q    <= cap_int_d;
            cap_pc_q     <= cap_pc_d;
            cap_ds_q     <= cap_ds_d;
            cap_bad_q    <= cap_bad_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
            exc_type_q   <= exc_type_d;
            int_commit_q <= int_commit_d;
            rvalid_q     <= rvalid_d;
            rpc_q        <= rpc_d;
            count_q      <= count_d;
        end
    end

    // Next state, victim capture and drain bookkeeping
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        timeout_d   = timeout_q;
        cap_type_d  = cap_type_q;
        cap_int_d   = cap_int_q;
        cap_pc_d    = cap_pc_q;
        cap_ds_d    = cap_ds_q;
        cap_bad_d   = cap_bad_q;
        case (state_q)
            IDLE: begin
                if (trigger_c) begin
                    // An exception type wins over a concurrent interrupt
                    cap_type_d = mem_exc_type;
                    cap_int_d  = (mem_exc_type == 8'h00);
                    cap_pc_d   = mem_pc;
                    cap_ds_d   = mem_is_delayslot;
                    cap_bad_d  = mem_badvaddr;
                    state_d    = bus_busy ? DRAIN : COMMIT;
                end
            end
            DRAIN: begin
                if (!bus_busy) begin
                    state_d     = COMMIT;
                    drain_cnt_d = '0;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = COMMIT;
                    drain_cnt_d = '0;
                    timeout_d   = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCNT_W'(1);
                end
            end
            COMMIT: state_d = REDIRECT;
            REDIRECT: begin
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        stall_d      = (state_d == DRAIN) || (state_d == COMMIT);
        flush_d      = (state_d == COMMIT) || (state_d == REDIRECT);
        exc_type_d   = (state_d == COMMIT) ? cap_type_d : 8'h00;
        int_commit_d = (state_d == COMMIT) && cap_int_d;
        rvalid_d     = (state_d == REDIRECT);
        rpc_d        = rpc_q;
        count_d      = count_q;
        if (state_q == COMMIT) begin
            rpc_d = cp0_exc_en ? cp0_pc_exc : FALLBACK_PC;
            if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
        end
    end

    assign stall            = stall_q;
    assign flush            = flush_q;
    assign cp0_exc_type     = exc_type_q;
    assign cp0_victim_pc    = cap_pc_q;
    assign cp0_is_delayslot = cap_ds_q;
    assign cp0_badvaddr     = cap_bad_q;
    assign cp0_int_commit   = int_commit_q;
    assign redirect_valid   = rvalid_q;
    assign redirect_pc      = rpc_q;
    assign drain_timeout    = timeout_q;
    assign exc_count        = count_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: directed triggers push expected commit and redirect
// records; a negedge monitor pops and compares whenever the DUT presents them.
module tb_exc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_exc_type = 8'h00;
    logic [31:0] mem_pc = 32'h0;
    logic        mem_is_delayslot = 1'b0;
    logic [31:0] mem_badvaddr = 32'h0;
    logic        int_pending = 1'b0;
    logic        bus_busy = 1'b0;
    logic        cp0_exc_en = 1'b0;
    logic [31:0] cp0_pc_exc = 32'h0;
    logic        redirect_ready = 1'b1;
    logic        stall, flush, cp0_is_delayslot, cp0_int_commit;
    logic        redirect_valid, drain_timeout;
    logic [7:0]  cp0_exc_type;
    logic [31:0] cp0_victim_pc, cp0_badvaddr, redirect_pc;
    logic [15:0] exc_count;

    exc_sequencer #(.DRAIN_MAX(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_exc_type(mem_exc_type), .mem_pc(mem_pc),
        .mem_is_delayslot(mem_is_delayslot), .mem_badvaddr(mem_badvaddr),
        .int_pending(int_pending), .bus_busy(bus_busy),
        .cp0_exc_en(cp0_exc_en), .cp0_pc_exc(cp0_pc_exc), .redirect_ready(redirect_ready),
        .stall(stall), .flush(flush), .cp0_exc_type(cp0_exc_type),
        .cp0_victim_pc(cp0_victim_pc), .cp0_is_delayslot(cp0_is_delayslot),
        .cp0_badvaddr(cp0_badvaddr), .cp0_int_commit(cp0_int_commit),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .drain_timeout(drain_timeout), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  typ;
        logic        intr;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        int          drain;
    } commit_t;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] count;
        logic        tmo;
    } redir_t;

    commit_t commit_q[$];
    redir_t  redir_q[$];
    int      errors = 0;
    int      checks = 0;
    int      stall_run = 0;
    logic    in_commit = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_run = 0;
            in_commit = 1'b0;
        end else begin
            if (in_commit) begin
                check("commit_pulse_type", {24'h0, cp0_exc_type}, 32'h0);
                check("commit_pulse_int", {31'h0, cp0_int_commit}, 32'h0);
                check("redirect_after_commit", {31'h0, redirect_valid}, 32'h1);
                in_commit = 1'b0;
            end
            if (cp0_exc_type != 8'h00 || cp0_int_commit) begin
                if (commit_q.size() == 0) begin
                    check("unexpected_commit", {24'h0, cp0_exc_type}, 32'h0);
                end else begin
                    commit_t e;
                    e = commit_q.pop_front();
                    check("exc_type", {24'h0, cp0_exc_type}, {24'h0, e.typ});
                    check("int_commit", {31'h0, cp0_int_commit}, {31'h0, e.intr});
                    check("victim_pc", cp0_victim_pc, e.pc);
                    check("delayslot", {31'h0, cp0_is_delayslot}, {31'h0, e.ds});
                    check("badvaddr", cp0_badvaddr, e.bad);
                    check("drain_cycles", 32'(stall_run), 32'(e.drain));
                    check("commit_stall_flush", {30'h0, stall, flush}, 32'h3);
                end
                in_commit = 1'b1;
                stall_run = 0;
            end else if (stall) begin
                stall_run++;
            end else begin
                stall_run = 0;
            end
            if (redirect_valid) begin
                if (redir_q.size() == 0) begin
                    check("unexpected_redirect", {31'h0, redirect_valid}, 32'h0);
                end else begin
                    check("redirect_pc", redirect_pc, redir_q[0].pc);
                    check("redirect_stall_flush", {30'h0, stall, flush}, 32'h1);
                    if (redirect_ready) begin
                        redir_t r;
                        r = redir_q.pop_front();
                        check("exc_count", {16'h0, exc_count}, {16'h0, r.count});
                        check("drain_timeout", {31'h0, drain_timeout}, {31'h0, r.tmo});
                    end
                end
            end
        end
    end

    task automatic fire(input logic [7:0] t, input logic ip, input logic [31:0] pc,
                        input logic ds, input logic [31:0] bad, input logic busy);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_exc_type = t; int_pending = ip; mem_pc = pc;
        mem_is_delayslot = ds; mem_badvaddr = bad; bus_busy = busy;
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_exc_type = 8'h00; int_pending = 1'b0;
    endtask

    task automatic expect_seq(input logic [7:0] t, input logic ip, input logic [31:0] pc,
                              input logic ds, input logic [31:0] bad, input int drain,
                              input logic [31:0] rpc, input logic [15:0] cnt, input logic tmo);
        commit_t c;
        redir_t  r;
        c.typ = t; c.intr = ip; c.pc = pc; c.ds = ds; c.bad = bad; c.drain = drain;
        r.pc = rpc; r.count = cnt; r.tmo = tmo;
        commit_q.push_back(c);
        redir_q.push_back(r);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((commit_q.size() != 0 || redir_q.size() != 0 || redirect_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) check("sequence_timeout", 32'(n), 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {24'h0, stall, flush, cp0_is_delayslot, cp0_int_commit,
                              redirect_valid, drain_timeout, 2'b00}, 32'h0);
        check({tag, "_type"}, {24'h0, cp0_exc_type}, 32'h0);
        check({tag, "_victim"}, cp0_victim_pc, 32'h0);
        check({tag, "_bad"}, cp0_badvaddr, 32'h0);
        check({tag, "_rpc"}, redirect_pc, 32'h0);
        check({tag, "_count"}, {16'h0, exc_count}, 32'h0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: Sys, bus idle
        cp0_exc_en = 1'b1; cp0_pc_exc = 32'hBFC0_0380;
        expect_seq(8'h02, 1'b0, 32'hBFC0_0100, 1'b0, 32'h0, 0, 32'hBFC0_0380, 16'd1, 1'b0);
        fire(8'h02, 1'b0, 32'hBFC0_0100, 1'b0, 32'h0, 1'b0);
        wait_done();

        // 2: AdES with bus busy for trigger cycle plus 4 drain cycles
        cp0_pc_exc = 32'h8000_0180;
        expect_seq(8'h80, 1'b0, 32'h8000_1000, 1'b0, 32'h8000_0003, 5, 32'h8000_0180, 16'd2, 1'b0);
        fire(8'h80, 1'b0, 32'h8000_1000, 1'b0, 32'h8000_0003, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        bus_busy = 1'b0;
        wait_done();

        // 3: drain timeout with bus stuck busy
        expect_seq(8'h10, 1'b0, 32'h8000_2000, 1'b0, 32'h0, 64, 32'h8000_0180, 16'd3, 1'b1);
        fire(8'h10, 1'b0, 32'h8000_2000, 1'b0, 32'h0, 1'b1);
        wait_done();
        bus_busy = 1'b0;
        check("timeout_sticky", {31'h0, drain_timeout}, 32'h1);

        // 4: Ov plus interrupt in a delay slot
        expect_seq(8'h08, 1'b0, 32'h8000_3004, 1'b1, 32'h0, 0, 32'h8000_0180, 16'd4, 1'b1);
        fire(8'h08, 1'b1, 32'h8000_3004, 1'b1, 32'h0, 1'b0);
        wait_done();

        // 5: interrupt only, CP0 withdraws, fetch stalls the redirect 3 cycles
        cp0_exc_en = 1'b0; cp0_pc_exc = 32'h1234_5678;
        redirect_ready = 1'b0;
        expect_seq(8'h00, 1'b1, 32'h8000_4000, 1'b0, 32'h0, 0, 32'hBFC0_0380, 16'd5, 1'b1);
        fire(8'h00, 1'b1, 32'h8000_4000, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20 && !redirect_valid; i++) begin @(posedge clk); #1; end
        repeat (3) begin @(posedge clk); #1; end
        redirect_ready = 1'b1;
        wait_done();
        check("idle_after_ready", {30'h0, stall, flush}, 32'h0);

        // 6: reset in the middle of a drain
        fire(8'h04, 1'b0, 32'h8000_5000, 1'b1, 32'h8000_5555, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_busy = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("post_reset_count", {16'h0, exc_count}, 32'h0);
        check("post_reset_idle", {30'h0, stall, redirect_valid}, 32'h0);
        check("queues_empty", 32'(commit_q.size() + redir_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
